reset_ctrl: RTL
===============

# reset_ctrl

Global reset controller: the source side of the local reset synchronizers used throughout the SoC. It combines the power-on/PLL-lock reset, a debounced front-panel reset button and a software reset request into one sequenced set of per-domain active-low resets. It holds all domains in reset for a minimum time, then releases them one by one in a fixed order. Each `rst_n_out[i]` drives the `arst_n` input of the local synchronizer in that domain.

## Interface
- `N_DOM`, default 3: number of reset domains (1..8).
- `HOLD_CYCLES`, default 1024: minimum clk cycles that all outputs stay low after any reset event (≥2).
- `STAGGER_CYCLES`, default 16: clk cycles between successive domain releases (≥1).
- `DEBOUNCE_CYCLES`, default 50000: stable cycles required before the button level is accepted (≥2).

Ports:
- `clk`, in, 1: controller clock, free-running.
- `arst_n`, in, 1: reset, asynchronous, active-low (power-on AND PLL lock).
- `btn_n`, in, 1: raw pushbutton, asynchronous, active-low, bouncy.
- `sw_rst_req`, in, 1: software reset request, one-cycle pulse, clk domain.
- `rst_n_out`, out, N_DOM: per-domain reset, active-low. Registered and glitch-free.
- `busy`, out, 1: high while any `rst_n_out` bit is low.
- `rst_cause`, out, 2: cause of the last reset. 00 = power-on, 01 = button, 10 = software.
- `rst_count`, out, 8: saturating count of button/software resets since power-on.

## Operation
- **Asynchronous reset.** While `arst_n` is low, with no clock needed:
  - `rst_n_out` = 0, `busy` = 1, `rst_cause` = 00, `rst_count` = 0.
  - Debounced button level = 1 (released); state = HOLD; counters = 0.
- **Internal deassertion.** `arst_n` deassertion is synchronized internally through 2 flops. The FSM leaves reset on the 2nd rising edge after `arst_n` rises.
- **Button path.**
  - `btn_n` passes through a 2-flop synchronizer.
  - The debounced level flips when the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - A 1→0 transition of the debounced level produces a one-cycle `press` event.
- **Reset event** = `press` OR `sw_rst_req`. Cause selection: button has priority (01), else software (10).
- **FSM.**
  - **HOLD:** all outputs 0. Hold counter counts up.
    - Exit to RELEASE when count reaches HOLD_CYCLES AND the debounced button level is 1.
    - If the button is still held, stay in HOLD with the counter saturated.
  - **RELEASE:** `rst_n_out[0]` set on the entry edge. Every further STAGGER_CYCLES, the next bit is set in ascending index order. The edge setting bit N_DOM-1 also moves to RUN.
  - **RUN:** all outputs 1, `busy` = 0.
- **Reset event in any state (HOLD/RELEASE/RUN)**, on the next rising edge:
  - All `rst_n_out` go to 0; `busy` = 1; state → HOLD; hold counter = 0.
  - `rst_cause` is updated; `rst_count` += 1, saturating at 255.
  - A release in progress is aborted. An event during HOLD restarts the hold.
- **Power-on reset** never increments `rst_count`.
- **Output glitch rule.** Outputs only fall on events. Outputs only rise in RELEASE, one bit per scheduled edge.

## Timing
- **Reset values:** `rst_n_out` = 0, `busy` = 1, `rst_cause` = 00, `rst_count` = 0.
- **Power-up schedule.** Let edge 0 = first rising edge with `arst_n` high, and assume the button is released:
  - `rst_n_out[i]` rises at edge HOLD_CYCLES + 1 + i·STAGGER_CYCLES.
  - `busy` falls with the last bit.
- **Event schedule.** Let E = the edge where outputs fall:
  - `rst_n_out[i]` rises at E + HOLD_CYCLES + i·STAGGER_CYCLES.
- **Software latency:** `sw_rst_req` sampled high at edge k → outputs low at edge k+1.
- **Button latency:** outputs fall 1 edge after the edge where the debounced level goes 0. That is roughly 2 + DEBOUNCE_CYCLES + 1 edges after a clean press.
- **Simultaneous press and `sw_rst_req`:** treated as one event, cause 01, count +1.
- **`sw_rst_req` held high:** re-triggers every cycle, so the block stays in HOLD. Each sampled-high edge is one event.

## Test plan
Parameters: N_DOM=3, HOLD_CYCLES=8, STAGGER_CYCLES=4, DEBOUNCE_CYCLES=16.

- **Power-up:** `arst_n` low 5 cycles, then high (edge 0), `btn_n`=1 → `rst_n_out` = 001 @ edge 9, 011 @ 13, 111 @ 17. `busy` falls @ 17. `rst_cause` = 00, `rst_count` = 0.
- **Software reset:** in RUN, pulse `sw_rst_req` sampled @ edge k → `rst_n_out` = 000 @ k+1. Then 001 @ k+9, 011 @ k+13, 111 @ k+17. `rst_cause` = 10, `rst_count` = 1.
- **Button bounce then press:**
  - Toggle `btn_n` every 5 cycles for 60 cycles → no event, `rst_count` unchanged.
  - Hold `btn_n` = 0 for 100 cycles → one reset, cause 01. Outputs remain 000 until ≥16 stable-high cycles after release, then the stagger schedule runs.
- **Simultaneous events:** press event and `sw_rst_req` in the same cycle → single event, `rst_cause` = 01, `rst_count` +1.
- **Abort during release:** `sw_rst_req` one edge after `rst_n_out` = 001 → 000 next edge, full schedule restarts from that edge, count +1.
- **Async reset mid-RUN:** drop `arst_n` with clk stopped → outputs 000 and `busy` = 1 immediately. `rst_count` = 0, `rst_cause` = 00.

Source files
------------

// File: rtl/reset_ctrl.sv
// Global reset controller: merges power-on, debounced pushbutton and software
// reset requests into a held-then-staggered set of per-domain active-low resets.
module reset_ctrl #(
   parameter int N_DOM           = 3,
   parameter int HOLD_CYCLES     = 1024,
   parameter int STAGGER_CYCLES  = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             btn_n,
   input  logic             sw_rst_req,
   output logic [N_DOM-1:0] rst_n_out,
   output logic             busy,
   output logic [1:0]       rst_cause,
   output logic [7:0]       rst_count
);
   localparam int HW = $clog2(HOLD_CYCLES);
   localparam int SW = $clog2(STAGGER_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_BTN = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;

   typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_RUN} state_t;

   logic             arst_sync1_reg;
   logic             run_en_reg;
   logic             btn_sync1_reg;
   logic             btn_sync2_reg;
   logic             btn_level_reg;
   logic [DW-1:0]    deb_cnt_reg;
   logic             press_reg;
   logic             sw_req_reg;
   state_t           state_reg;
   logic [HW-1:0]    hold_cnt_reg;
   logic [SW-1:0]    stag_cnt_reg;
   logic [N_DOM-1:0] rst_n_out_reg;
   logic             busy_reg;
   logic [1:0]       cause_reg;
   logic [7:0]       count_reg;
   logic [N_DOM-1:0] rst_n_shift;
   logic             reset_event;
   logic             release_step;

   // Asynchronous assertion, synchronized release of the controller itself.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         arst_sync1_reg <= 1'b0;
         run_en_reg     <= 1'b0;
      end else begin
         arst_sync1_reg <= 1'b1;
         run_en_reg     <= arst_sync1_reg;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         btn_sync1_reg <= 1'b1;
         btn_sync2_reg <= 1'b1;
         btn_level_reg <= 1'b1;
         deb_cnt_reg   <= '0;
         press_reg     <= 1'b0;
         sw_req_reg    <= 1'b0;
      end else begin
         btn_sync1_reg <= btn_n;
         btn_sync2_reg <= btn_sync1_reg;
         sw_req_reg    <= sw_rst_req;
         press_reg     <= 1'b0;
         if (btn_sync2_reg == btn_level_reg) begin
            deb_cnt_reg <= '0;
         end else if (deb_cnt_reg == DEB_LAST) begin
            deb_cnt_reg   <= '0;
            btn_level_reg <= btn_sync2_reg;
            // Only a released-to-pressed flip is a press.
            press_reg     <= btn_level_reg;
         end else begin
            deb_cnt_reg <= deb_cnt_reg + DW'(1);
         end
      end
   end

   generate
      if (N_DOM == 1) begin : g_single
         assign rst_n_shift = 1'b1;
      end else begin : g_multi
         assign rst_n_shift = {rst_n_out_reg[N_DOM-2:0], 1'b1};
      end
   endgenerate

   assign reset_event = press_reg | sw_req_reg;

   always_comb begin
      release_step = 1'b0;
      case (state_reg)
         ST_HOLD:    release_step = (hold_cnt_reg == HOLD_LAST) && btn_level_reg;
         ST_RELEASE: release_step = (stag_cnt_reg == STAG_LAST);
         default:    release_step = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_reg     <= ST_HOLD;
         hold_cnt_reg  <= '0;
         stag_cnt_reg  <= '0;
         rst_n_out_reg <= '0;
         busy_reg      <= 1'b1;
         cause_reg     <= CAUSE_POR;
         count_reg     <= '0;
      end else if (run_en_reg) begin
         if (reset_event) begin
            state_reg     <= ST_HOLD;
            hold_cnt_reg  <= '0;
            rst_n_out_reg <= '0;
            busy_reg      <= 1'b1;
            cause_reg     <= press_reg ? CAUSE_BTN : CAUSE_SW;
            if (count_reg != 8'hFF) begin
               count_reg <= count_reg + 8'd1;
            end
         end else if (release_step) begin
            rst_n_out_reg <= rst_n_shift;
            stag_cnt_reg  <= '0;
            if (rst_n_shift[N_DOM-1]) begin
               state_reg <= ST_RUN;
               busy_reg  <= 1'b0;
            end else begin
               state_reg <= ST_RELEASE;
            end
         end else if (state_reg == ST_HOLD) begin
            // Saturates at the last count while the button is still held.
            if (hold_cnt_reg != HOLD_LAST) begin
               hold_cnt_reg <= hold_cnt_reg + HW'(1);
            end
         end else if (state_reg == ST_RELEASE) begin
            stag_cnt_reg <= stag_cnt_reg + SW'(1);
         end
      end
   end

   assign rst_n_out = rst_n_out_reg;
   assign busy      = busy_reg;
   assign rst_cause = cause_reg;
   assign rst_count = count_reg;
endmodule
